// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers the displayed hex digits.
// A digit is captured after STABLE unchanged cycles; complete frames leave on valid/ready.
module seg7_scan_decoder #(
    parameter int NDIG   = 8,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] frame_digits,
    output logic [NDIG-1:0]   frame_blank,
    output logic [NDIG-1:0]   frame_err,
    output logic [NDIG-1:0]   frame_dp,
    output logic              frame_valid,
    input  logic              frame_ready
);
    localparam int            CW       = $clog2(STABLE + 1);
    localparam int            IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

    typedef enum logic [1:0] {ST_WAIT, ST_COUNT, ST_TAKEN} state_e;

    logic [7:0]        seg_q, seg_d, seg_prev_q, seg_prev_d;
    logic [NDIG-1:0]   an_q, an_d, an_prev_q, an_prev_d;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] slot_digit_q, slot_digit_d;
    logic [NDIG-1:0]   slot_blank_q, slot_blank_d;
    logic [NDIG-1:0]   slot_err_q, slot_err_d;
    logic [NDIG-1:0]   slot_dp_q, slot_dp_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] frame_digits_q, frame_digits_d;
    logic [NDIG-1:0]   frame_blank_q, frame_blank_d;
    logic [NDIG-1:0]   frame_err_q, frame_err_d;
    logic [NDIG-1:0]   frame_dp_q, frame_dp_d;
    logic              frame_valid_q, frame_valid_d;

    logic [7:0]        pat;
    logic [3:0]        dec_nib;
    logic              dec_blank, dec_err, dec_dp;
    logic [IW-1:0]     sel_idx;
    logic              sel_legal;
    int                n_low;
    logic              changed, accept, emit;

    // Glyph decode of the registered bus sample; dp is masked out of the match.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pat       = ~seg_q & 8'hFE;
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        dec_dp    = ~seg_q[0];
        case (pat)
            8'hFC: dec_nib = 4'h0;
            8'h60: dec_nib = 4'h1;
            8'hDA: dec_nib = 4'h2;
            8'hF2: dec_nib = 4'h3;
            8'h66: dec_nib = 4'h4;
            8'hB6: dec_nib = 4'h5;
            8'hBE: dec_nib = 4'h6;
            8'hE0: dec_nib = 4'h7;
            8'hFE: dec_nib = 4'h8;
            8'hE6: dec_nib = 4'h9;
            8'hEE: dec_nib = 4'hA;
            8'h3E: dec_nib = 4'hB;
            8'h9C: dec_nib = 4'hC;
            8'h7A: dec_nib = 4'hD;
            8'h9E: dec_nib = 4'hE;
            8'h8E: dec_nib = 4'hF;
            8'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        sel_idx = '0;
        n_low   = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_q[i]) begin
                n_low   = n_low + 1;
                sel_idx = IW'(i);
            end
        end
        sel_legal = (n_low == 1);
    end

    assign changed = (seg_q != seg_prev_q) || (an_q != an_prev_q);

    // Dwell tracker: a fresh or illegal sample restarts the count at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (changed || !sel_legal || state_q == ST_WAIT) begin
            cnt_d = CW'(1);
            if (!sel_legal) begin
                state_d = ST_WAIT;
            end else if (STABLE == 1) begin
                accept  = 1'b1;
                state_d = ST_TAKEN;
            end else begin
                state_d = ST_COUNT;
            end
        end else if (state_q == ST_COUNT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == STABLE_C) begin
                accept  = 1'b1;
                state_d = ST_TAKEN;
            end
        end
    end

    always_comb begin
        seg_d          = seg_n;
        an_d           = an_n;
        seg_prev_d     = seg_q;
        an_prev_d      = an_q;
        slot_digit_d   = slot_digit_q;
        slot_blank_d   = slot_blank_q;
        slot_err_d     = slot_err_q;
        slot_dp_d      = slot_dp_q;
        seen_d         = seen_q;
        frame_digits_d = frame_digits_q;
        frame_blank_d  = frame_blank_q;
        frame_err_d    = frame_err_q;
        frame_dp_d     = frame_dp_q;
        frame_valid_d  = frame_valid_q;
        emit           = (&seen_q) && (!frame_valid_q || frame_ready);

        if (emit) begin
            frame_digits_d = slot_digit_q;
            frame_blank_d  = slot_blank_q;
            frame_err_d    = slot_err_q;
            frame_dp_d     = slot_dp_q;
            frame_valid_d  = 1'b1;
            seen_d         = '0;
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end

        // Applied after the clear so a same-cycle accept seeds the next frame.
        if (accept) begin
            slot_digit_d[{sel_idx, 2'b00} +: 4] = dec_nib;
            slot_blank_d[sel_idx]               = dec_blank;
            slot_err_d[sel_idx]                 = dec_err;
            slot_dp_d[sel_idx]                  = dec_dp;
            seen_d[sel_idx]                     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: slots are reset too, so a frame can never expose power-up contents.
            seg_q          <= '1;
            an_q           <= '1;
            seg_prev_q     <= '1;
            an_prev_q      <= '1;
            state_q        <= ST_WAIT;
            cnt_q          <= '0;
            slot_digit_q   <= '0;
            slot_blank_q   <= '0;
            slot_err_q     <= '0;
            slot_dp_q      <= '0;
            seen_q         <= '0;
            frame_digits_q <= '0;
            frame_blank_q  <= '0;
            frame_err_q    <= '0;
            frame_dp_q     <= '0;
            frame_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates, so every flop samples the pre-edge values.
            seg_q          <= seg_d;
            an_q           <= an_d;
            seg_prev_q     <= seg_prev_d;
            an_prev_q      <= an_prev_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            slot_digit_q   <= slot_digit_d;
            slot_blank_q   <= slot_blank_d;
            slot_err_q     <= slot_err_d;
            slot_dp_q      <= slot_dp_d;
            seen_q         <= seen_d;
            frame_digits_q <= frame_digits_d;
            frame_blank_q  <= frame_blank_d;
            frame_err_q    <= frame_err_d;
            frame_dp_q     <= frame_dp_d;
            frame_valid_q  <= frame_valid_d;
        end
    end

    assign frame_digits = frame_digits_q;
    assign frame_blank  = frame_blank_q;
    assign frame_err    = frame_err_q;
    assign frame_dp     = frame_dp_q;
    assign frame_valid  = frame_valid_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder, checked each cycle against a
// run-length reference model of the display bus.
module tb_seg7_scan_decoder;
    localparam int NDIG   = 4;
    localparam int STABLE = 4;
    localparam logic [7:0] GLYPH [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                          8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    typedef struct packed {
        logic              valid;
        logic [4*NDIG-1:0] digits;
        logic [NDIG-1:0]   blank;
        logic [NDIG-1:0]   err;
        logic [NDIG-1:0]   dp;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        seg_n;
    logic [NDIG-1:0]   an_n;
    logic [4*NDIG-1:0] frame_digits;
    logic [NDIG-1:0]   frame_blank, frame_err, frame_dp;
    logic              frame_valid;
    logic              frame_ready;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .frame_digits(frame_digits), .frame_blank(frame_blank), .frame_err(frame_err),
        .frame_dp(frame_dp), .frame_valid(frame_valid), .frame_ready(frame_ready)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    int     valid_cycles = 0;
    int     handshakes = 0;
    frame_t last_frame;

    // Reference model: run length of the current bus value plus per-slot captures.
    logic [7:0]      m_last_seg;
    logic [NDIG-1:0] m_last_an;
    int              m_run;
    bit              m_pend;
    int              m_pend_slot;
    logic [6:0]      m_pend_val;
    logic [6:0]      m_slot [NDIG];
    bit              m_seen [NDIG];
    frame_t          m_frame;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [7:0] seg);
        logic [7:0] pat = ~seg & 8'hFE;
        logic [6:0] r   = {4'h0, 1'b0, 1'b1, ~seg[0]};
        if (pat == 8'h00) r = {4'h0, 1'b1, 1'b0, ~seg[0]};
        for (int j = 0; j < 16; j++)
            if (GLYPH[j] == pat) r = {4'(j), 2'b00, ~seg[0]};
        return r;
    endfunction

    function automatic int low_slot(input logic [NDIG-1:0] an);
        int n = 0;
        int s = -1;
        for (int i = 0; i < NDIG; i++)
            if (!an[i]) begin
                n++;
                s = i;
            end
        return (n == 1) ? s : -1;
    endfunction

    task automatic model_reset();
        m_last_seg = '1;
        m_last_an  = '1;
        m_run      = 0;
        m_pend     = 0;
        m_frame    = '0;
        for (int i = 0; i < NDIG; i++) begin
            m_slot[i] = '0;
            m_seen[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit full = 1;
        int sl;
        for (int i = 0; i < NDIG; i++) full &= m_seen[i];
        if (full && (!m_frame.valid || frame_ready)) begin
            for (int i = 0; i < NDIG; i++) begin
                m_frame.digits[4*i +: 4] = m_slot[i][6:3];
                m_frame.blank[i]         = m_slot[i][2];
                m_frame.err[i]           = m_slot[i][1];
                m_frame.dp[i]            = m_slot[i][0];
                m_seen[i]                = 0;
            end
            m_frame.valid = 1'b1;
        end else if (m_frame.valid && frame_ready) begin
            m_frame.valid = 1'b0;
        end
        if (m_pend) begin
            m_slot[m_pend_slot] = m_pend_val;
            m_seen[m_pend_slot] = 1;
        end
        if (seg_n == m_last_seg && an_n == m_last_an) m_run++;
        else m_run = 1;
        m_last_seg  = seg_n;
        m_last_an   = an_n;
        sl          = low_slot(an_n);
        m_pend      = (m_run == STABLE) && (sl >= 0);
        m_pend_slot = sl;
        m_pend_val  = ref_glyph(seg_n);
    endtask

    task automatic step(input logic [7:0] seg, input logic [NDIG-1:0] an, input logic rdy);
        frame_t obs;
        seg_n       = seg;
        an_n        = an;
        frame_ready = rdy;
        if (frame_valid && frame_ready) handshakes++;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        obs = {frame_valid, frame_digits, frame_blank, frame_err, frame_dp};
        if (frame_valid) begin
            valid_cycles++;
            last_frame = obs;
        end
        check("frame", 64'(obs), 64'(m_frame));
    endtask

    task automatic dwell(input int d, input logic [7:0] pat, input int cyc, input logic rdy);
        logic [NDIG-1:0] an = ~(NDIG'(1) << d);
        repeat (cyc) step(~pat, an, rdy);
    endtask

    task automatic idle(input int cyc, input logic rdy);
        repeat (cyc) step(8'hFF, '1, rdy);
    endtask

    task automatic scan(input logic [15:0] nibs, input int cyc, input logic rdy);
        for (int d = 0; d < NDIG; d++) dwell(d, GLYPH[nibs[4*d +: 4]], cyc, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, len, r, gi;
        logic [7:0] pat;
        logic [NDIG-1:0] an;
        frame_t obs;

        rst_n = 1'b0; seg_n = 8'hFF; an_n = '1; frame_ready = 1'b0;
        model_reset();
        #2;
        obs = {frame_valid, frame_digits, frame_blank, frame_err, frame_dp};
        check("reset_state", 64'(obs), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Clean scan of 0..3 with ready high: exactly one single-cycle frame.
        valid_cycles = 0;
        scan(16'h3210, 6, 1'b1);
        idle(4, 1'b1);
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_digits", last_frame.digits, 16'h3210);
        check("t1_blank_err", {last_frame.blank, last_frame.err}, 8'h00);

        // Short dwell on digit 2 is ignored until it is held long enough.
        valid_cycles = 0;
        dwell(0, GLYPH[0], 6, 1'b1); dwell(1, GLYPH[1], 6, 1'b1);
        dwell(2, GLYPH[2], 3, 1'b1); dwell(3, GLYPH[3], 6, 1'b1);
        idle(6, 1'b1);
        check("t2_no_frame", valid_cycles, 0);
        dwell(2, GLYPH[2], 6, 1'b1);
        idle(4, 1'b1);
        check("t2_valid_cycles", valid_cycles, 1);
        check("t2_digits", last_frame.digits, 16'h3210);

        // dp-only reads as blank with dp; a lone g segment is an error.
        dwell(0, GLYPH[0], 6, 1'b1); dwell(1, 8'h01, 6, 1'b1);
        dwell(2, GLYPH[2], 6, 1'b1); dwell(3, GLYPH[3], 6, 1'b1);
        idle(4, 1'b1);
        check("t3_blank", last_frame.blank, 4'b0010);
        check("t3_dp", last_frame.dp, 4'b0010);
        check("t3_digits", last_frame.digits, 16'h3200);
        dwell(0, GLYPH[0], 6, 1'b1); dwell(1, 8'h02, 6, 1'b1);
        dwell(2, GLYPH[2], 6, 1'b1); dwell(3, GLYPH[3], 6, 1'b1);
        idle(4, 1'b1);
        check("t3_err", last_frame.err, 4'b0010);
        check("t3_err_dp", last_frame.dp, 4'b0000);

        // Illegal anodes never capture, even with three slots already seen.
        dwell(0, GLYPH[4], 6, 1'b1); dwell(1, GLYPH[5], 6, 1'b1); dwell(2, GLYPH[6], 6, 1'b1);
        valid_cycles = 0;
        repeat (20) step(~GLYPH[7], 4'b1111, 1'b1);
        repeat (20) step(~GLYPH[7], 4'b1100, 1'b1);
        repeat (20) step(~GLYPH[7], 4'b0011, 1'b1);
        check("t4_no_frame", valid_cycles, 0);
        dwell(3, GLYPH[7], 6, 1'b1);
        idle(4, 1'b1);
        check("t4_digits", last_frame.digits, 16'h7654);

        // Backpressure: the held frame stays put while collection continues.
        scan(16'h3215, 6, 1'b0);
        idle(2, 1'b0);
        repeat (3) scan(16'h3217, 6, 1'b0);
        check("t5_hold_valid", frame_valid, 1'b1);
        check("t5_hold_digit0", frame_digits[3:0], 4'h5);
        handshakes = 0;
        idle(1, 1'b1);
        idle(3, 1'b0);
        check("t5_next_valid", frame_valid, 1'b1);
        check("t5_next_digit0", frame_digits[3:0], 4'h7);
        idle(7, 1'b1);
        check("t5_handshakes", handshakes, 2);
        check("t5_drained", frame_valid, 1'b0);

        // Asynchronous reset mid-dwell with a frame pending.
        scan(16'h3210, 6, 1'b0);
        idle(2, 1'b0);
        dwell(0, GLYPH[5], 2, 1'b0);
        rst_n = 1'b0;
        #1;
        obs = {frame_valid, frame_digits, frame_blank, frame_err, frame_dp};
        check("t6_async_reset", 64'(obs), 64'd0);
        model_reset();
        idle(2, 1'b1);
        rst_n = 1'b1;
        valid_cycles = 0;
        dwell(0, GLYPH[9], 6, 1'b1); dwell(1, GLYPH[10], 6, 1'b1); dwell(2, GLYPH[11], 6, 1'b1);
        idle(6, 1'b1);
        check("t6_no_stale_frame", valid_cycles, 0);
        dwell(3, GLYPH[12], 6, 1'b1);
        idle(4, 1'b1);
        check("t6_valid_cycles", valid_cycles, 1);
        check("t6_digits", last_frame.digits, 16'hCBA9);

        // Random dwells, glyphs, anode patterns and consumer stalls.
        for (int k = 0; k < 400; k++) begin
            d   = $urandom_range(0, NDIG);
            len = $urandom_range(1, 7);
            r   = $urandom_range(0, 9);
            gi  = $urandom_range(0, 15);
            if (r < 7) pat = GLYPH[gi] | 8'($urandom_range(0, 1));
            else if (r == 7) pat = 8'($urandom_range(0, 1));
            else pat = 8'($urandom_range(0, 255));
            if (d == NDIG) an = NDIG'($urandom_range(0, 15));
            else an = ~(NDIG'(1) << d);
            repeat (len) step(~pat, an, $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
